branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Back-end counterpart to the front-end static branch predictor. It tracks every speculative prediction the FE issues in an in-order queue and checks each one against the execute-stage outcome. On a mispredict it flushes the queue and the wrong path, then issues a redirect PC to the FE with a valid/ready handshake.

Parameters:
DEPTH, 4, number of outstanding speculative branches tracked; power of 2, at least 2
PC_WIDTH, 16, width of all PC/target fields

Ports:
clk_i  input  1  clock
reset_i  input  1  synchronous active-high reset
pred_v_i  input  1  FE presents a branch prediction
pred_ready_o  output  1  queue can accept a prediction
pred_taken_i  input  1  FE predicted taken
pred_spec_i  input  1  prediction is speculative; only these are enqueued
pred_target_i  input  PC_WIDTH  predicted taken target
pred_fallthru_i  input  PC_WIDTH  PC of next sequential instruction
resolve_v_i  input  1  execute resolves the oldest speculative branch
resolve_taken_i  input  1  actual direction
resolve_target_i  input  PC_WIDTH  actual target; valid when resolve_taken_i=1
redirect_v_o  output  1  redirect request to FE
redirect_ready_i  input  1  FE accepts the redirect
redirect_pc_o  output  PC_WIDTH  corrected fetch PC
flush_o  output  1  one-cycle wrong-path kill to the pipeline
outstanding_o  output  $clog2(DEPTH)+1  queue occupancy
err_o  output  1  sticky: resolve arrived with an empty queue

Behaviour:
- Reset is synchronous active-high on clk_i:
  - queue empty, state RUN, err_o=0
  - redirect_v_o=0, flush_o=0, redirect_pc_o=0, outstanding_o=0
- Reset mid-redirect drops the pending redirect without a handshake.
- Enqueue fires when pred_v_i & pred_ready_o & pred_spec_i. Each entry stores {taken, target, fallthru}.
- pred_v_i with pred_spec_i=0 is accepted (ready still applies) and not stored.
- pred_ready_o = (state==RUN) & !full. It does not look at a same-cycle pop.
- A resolve fires when resolve_v_i=1 in state RUN; it always refers to the head entry.
- Mispredict conditions:
  - resolve_taken_i != head.taken
  - or (resolve_taken_i & resolve_target_i != head.target)
- Correct resolve: pop the head. A same-cycle enqueue also proceeds, so occupancy is unchanged.
- Mispredict in cycle N:
  - queue is cleared (clear beats any same-cycle enqueue; that entry is wrong-path and dropped)
  - redirect_pc_o <= resolve_taken_i ? resolve_target_i : head.fallthru
  - state <= REDIRECT
- In cycle N+1: redirect_v_o=1 and flush_o=1. flush_o lasts exactly 1 cycle.
- REDIRECT state:
  - redirect_v_o and redirect_pc_o held stable until redirect_ready_i=1
  - on that cycle, return to RUN; redirect_v_o=0 next cycle
  - resolve_v_i and pred_v_i are ignored; pred_ready_o=0
- Resolve with an empty queue in RUN: no pop, no redirect, err_o<=1 (sticky until reset).
- Pointers wrap modulo DEPTH. Occupancy uses a separate count, so DEPTH entries are distinguishable from empty.
- Latency: mispredict to redirect_v_o is 1 cycle. Minimum resolve-to-next-enqueue after a redirect is 2 cycles.

Optional Feature:
- BRANCH_RESOLVE_STATS_EN defined adds two output ports, both saturating at all-ones and reset to 0:
  - resolved_cnt_o [15:0]: increments on every resolve that fires
  - mispredict_cnt_o [15:0]: increments on every mispredict
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fe_pkg:
  - PC_WIDTH default constant
  - branch_entry_t struct {taken, target, fallthru}
  - bru_state_e enum {BRU_RUN, BRU_REDIRECT}
- One sub-module, branch_entry_fifo: parameterized DEPTH, element type branch_entry_t, with push, pop, clear, full, empty, count and head outputs. Clear takes priority over push and pop.
- The FSM, compare logic and redirect register stay in branch_resolve_unit.

Test Plan:
- Enqueue 4 speculative predictions (DEPTH=4), then present a fifth -> pred_ready_o=0, outstanding_o=4, fifth not stored.
- Head {taken=1, target=0x0040}, resolve taken, target 0x0040 -> pop, no flush, outstanding_o decrements by 1.
- Head {taken=0, fallthru=0x0102}, resolve taken, target 0x0200 -> next cycle redirect_v_o=1, flush_o=1, redirect_pc_o=0x0200; queue cleared.
- Head {taken=1, fallthru=0x0102}, resolve not taken -> redirect_pc_o=0x0102. Hold redirect_ready_i=0 for 3 cycles -> redirect_v_o and redirect_pc_o stable and flush_o high only in the first cycle; ready=1 -> back to RUN.
- Resolve with an empty queue -> err_o=1 and no redirect. Assert reset_i during REDIRECT -> next cycle redirect_v_o=0, err_o=0, outstanding_o=0.
- With BRANCH_RESOLVE_STATS_EN: 3 correct + 2 mispredicted resolves -> resolved_cnt_o=5, mispredict_cnt_o=2.

Source files
------------

// File: rtl/fe_pkg.sv
// fe_pkg: shared types for the front-end predictor and back-end branch resolve unit.
package fe_pkg;

    localparam int PC_WIDTH = 16;

    typedef struct packed {
        logic                taken;
        logic [PC_WIDTH-1:0] target;
        logic [PC_WIDTH-1:0] fallthru;
    } branch_entry_t;

    typedef enum logic {
        BRU_RUN,
        BRU_REDIRECT
    } bru_state_e;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: prediction, resolve and redirect handshakes between FE/EX (master) and the resolve unit (slave).
interface branch_resolve_unit_if #(parameter int PC_WIDTH = fe_pkg::PC_WIDTH);
    logic                pred_v;
    logic                pred_ready;
    logic                pred_taken;
    logic                pred_spec;
    logic [PC_WIDTH-1:0] pred_target;
    logic [PC_WIDTH-1:0] pred_fallthru;
    logic                resolve_v;
    logic                resolve_taken;
    logic [PC_WIDTH-1:0] resolve_target;
    logic                redirect_v;
    logic                redirect_ready;
    logic [PC_WIDTH-1:0] redirect_pc;

    modport master (
        output pred_v, pred_taken, pred_spec, pred_target, pred_fallthru,
        output resolve_v, resolve_taken, resolve_target, redirect_ready,
        input  pred_ready, redirect_v, redirect_pc
    );

    modport slave (
        input  pred_v, pred_taken, pred_spec, pred_target, pred_fallthru,
        input  resolve_v, resolve_taken, resolve_target, redirect_ready,
        output pred_ready, redirect_v, redirect_pc
    );
endinterface

// File: rtl/branch_entry_fifo.sv
// branch_entry_fifo: in-order queue of speculative branches; clear wins over push and pop.
module branch_entry_fifo
    import fe_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = branch_entry_t
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  entry_t                   data_i,
    output entry_t                   head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_q] <= data_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two; the count separates full from empty.
    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks FE speculative predictions against execute outcomes and redirects on mispredict.
// Define BRANCH_RESOLVE_STATS_EN to add saturating resolve/mispredict counters.
module branch_resolve_unit
    import fe_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = fe_pkg::PC_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    branch_resolve_unit_if.slave       bus,
    output logic                       flush_o,
    output logic [$clog2(DEPTH):0]     outstanding_o,
`ifdef BRANCH_RESOLVE_STATS_EN
    output logic [15:0]                resolved_cnt_o,
    output logic [15:0]                mispredict_cnt_o,
`endif
    output logic                       err_o
);
    bru_state_e          state_q;
    logic                redirect_v_q, flush_q, err_q;
    logic [PC_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
    branch_entry_t       head, new_entry;
    logic                full, empty, run, push, res_fire, hit, mispredict;

    assign run        = state_q == BRU_RUN;
    assign push       = bus.pred_v & bus.pred_ready & bus.pred_spec;
    assign res_fire   = bus.resolve_v & run;
    assign hit        = res_fire & ~empty;
    assign mispredict = hit & ((bus.resolve_taken != head.taken) |
                               (bus.resolve_taken & (bus.resolve_target != head.target)));
    assign redirect_pc_d = bus.resolve_taken ? bus.resolve_target : head.fallthru;
    assign new_entry  = '{taken: bus.pred_taken, target: bus.pred_target, fallthru: bus.pred_fallthru};

    assign bus.pred_ready  = run & ~full;
    assign bus.redirect_v  = redirect_v_q;
    assign bus.redirect_pc = redirect_pc_q;
    assign flush_o         = flush_q;
    assign err_o           = err_q;

    // A mispredict clears the queue, so any same-cycle enqueue is wrong-path and dropped.
    branch_entry_fifo #(.DEPTH(DEPTH), .entry_t(branch_entry_t)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (hit & ~mispredict),
        .clear_i (mispredict),
        .data_i  (new_entry),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= BRU_RUN;
            redirect_v_q  <= 1'b0;
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            flush_q <= mispredict;
            if (res_fire && empty) err_q <= 1'b1;
            if (mispredict) begin
                state_q       <= BRU_REDIRECT;
                redirect_v_q  <= 1'b1;
                redirect_pc_q <= redirect_pc_d;
            end else if (state_q == BRU_REDIRECT && bus.redirect_ready) begin
                state_q      <= BRU_RUN;
                redirect_v_q <= 1'b0;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] resolved_cnt_q, mispredict_cnt_q;

    assign resolved_cnt_o   = resolved_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            resolved_cnt_q   <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (res_fire && !(&resolved_cnt_q)) resolved_cnt_q <= resolved_cnt_q + 16'd1;
            if (mispredict && !(&mispredict_cnt_q)) mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed stimulus checked every cycle against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    typedef struct {
        bit          taken;
        logic [15:0] target;
        logic [15:0] fallthru;
    } ent_t;

    logic clk = 1'b0;
    logic reset_i;
    logic flush;
    logic [2:0] outstanding;
    logic err;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [15:0] resolved_cnt, mispredict_cnt;
`endif

    branch_resolve_unit_if #(.PC_WIDTH(16)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .PC_WIDTH(16)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .bus              (bus),
        .flush_o          (flush),
        .outstanding_o    (outstanding),
`ifdef BRANCH_RESOLVE_STATS_EN
        .resolved_cnt_o   (resolved_cnt),
        .mispredict_cnt_o (mispredict_cnt),
`endif
        .err_o            (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    ent_t        mq[$];
    bit          m_redir = 0, m_flush = 0, m_err = 0;
    logic [15:0] m_rpc = 0, m_res = 0, m_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: applies the inputs seen at a rising edge to the abstract queue state.
    task automatic model_update();
        bit   mis, do_push;
        ent_t h;
        if (reset_i) begin
            mq.delete();
            m_redir = 0; m_flush = 0; m_err = 0; m_rpc = 0; m_res = 0; m_mis = 0;
            return;
        end
        m_flush = 0;
        if (m_redir) begin
            if (bus.redirect_ready) m_redir = 0;
            return;
        end
        mis = 0;
        do_push = bus.pred_v && bus.pred_spec && mq.size() < DEPTH;
        if (bus.resolve_v) begin
            if (m_res != 16'hffff) m_res++;
            if (mq.size() == 0) m_err = 1;
            else begin
                h = mq[0];
                if (bus.resolve_taken != h.taken || (bus.resolve_taken && bus.resolve_target != h.target)) begin
                    mis = 1;
                    m_rpc = bus.resolve_taken ? bus.resolve_target : h.fallthru;
                    mq.delete();
                    m_redir = 1;
                    m_flush = 1;
                    if (m_mis != 16'hffff) m_mis++;
                end else void'(mq.pop_front());
            end
        end
        if (do_push && !mis) mq.push_back('{bus.pred_taken, bus.pred_target, bus.pred_fallthru});
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pred_ready", 32'(bus.pred_ready), 32'(!m_redir && mq.size() < DEPTH));
            chk("redirect_v", 32'(bus.redirect_v), 32'(m_redir));
            chk("redirect_pc", 32'(bus.redirect_pc), 32'(m_rpc));
            chk("flush", 32'(flush), 32'(m_flush));
            chk("outstanding", 32'(outstanding), 32'(mq.size()));
            chk("err", 32'(err), 32'(m_err));
`ifdef BRANCH_RESOLVE_STATS_EN
            chk("resolved_cnt", 32'(resolved_cnt), 32'(m_res));
            chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mis));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        bus.pred_v = 0; bus.pred_taken = 0; bus.pred_spec = 0;
        bus.pred_target = 0; bus.pred_fallthru = 0;
        bus.resolve_v = 0; bus.resolve_taken = 0; bus.resolve_target = 0;
        bus.redirect_ready = 0;
    endtask

    task automatic set_pred(input bit t, input logic [15:0] tgt, input logic [15:0] ft);
        bus.pred_v = 1; bus.pred_spec = 1; bus.pred_taken = t;
        bus.pred_target = tgt; bus.pred_fallthru = ft;
    endtask

    task automatic set_res(input bit t, input logic [15:0] tgt);
        bus.resolve_v = 1; bus.resolve_taken = t; bus.resolve_target = tgt;
    endtask

    task automatic push(input bit t, input logic [15:0] tgt, input logic [15:0] ft);
        set_pred(t, tgt, ft); tick(); idle();
    endtask

    task automatic resolve(input bit t, input logic [15:0] tgt);
        set_res(t, tgt); tick(); idle();
    endtask

    task automatic resolve_head_ok();
        set_res(mq[0].taken, mq[0].taken ? mq[0].target : 16'hdead);
    endtask

    task automatic accept_redirect();
        bus.redirect_ready = 1; tick(); idle();
    endtask

    initial begin
        idle();
        reset_i = 1;
        tick(); tick();
        reset_i = 0;
        chk_en = 1;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_redirect_v", 32'(bus.redirect_v), 32'd0);
        chk("rst_redirect_pc", 32'(bus.redirect_pc), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        push(1, 16'h0040, 16'h0012);
        push(0, 16'h0080, 16'h0102);
        push(1, 16'h0300, 16'h0104);
        push(1, 16'h0400, 16'h0106);
        chk("full_ready", 32'(bus.pred_ready), 32'd0);
        chk("full_outstanding", 32'(outstanding), 32'd4);
        push(1, 16'h0500, 16'h0108);
        chk("fifth_dropped", 32'(outstanding), 32'd4);

        resolve(1, 16'h0040);
        chk("pop_outstanding", 32'(outstanding), 32'd3);
        chk("pop_no_flush", 32'(flush), 32'd0);

        resolve(1, 16'h0200);
        chk("mis_redirect_v", 32'(bus.redirect_v), 32'd1);
        chk("mis_flush", 32'(flush), 32'd1);
        chk("mis_pc", 32'(bus.redirect_pc), 32'h0200);
        chk("mis_cleared", 32'(outstanding), 32'd0);
        tick();
        chk("flush_one_cycle", 32'(flush), 32'd0);
        accept_redirect();
        chk("back_to_run", 32'(bus.pred_ready), 32'd1);

        bus.pred_v = 1; bus.pred_spec = 0; bus.pred_taken = 1; bus.pred_target = 16'h0777;
        tick(); idle();
        chk("nonspec_not_stored", 32'(outstanding), 32'd0);

        push(1, 16'h0500, 16'h0102);
        set_pred(1, 16'h0600, 16'h0102); set_res(1, 16'h0500); tick(); idle();
        chk("pop_push_same", 32'(outstanding), 32'd1);

        set_pred(0, 16'h0700, 16'h0702); set_res(0, 16'h0000); tick(); idle();
        chk("nt_mis_pc", 32'(bus.redirect_pc), 32'h0102);
        chk("nt_mis_push_dropped", 32'(outstanding), 32'd0);
        for (int i = 0; i < 2; i++) begin
            set_pred(1, 16'h0abc, 16'h0abe); set_res(1, 16'h0abc); tick(); idle();
            chk("hold_v", 32'(bus.redirect_v), 32'd1);
            chk("hold_pc", 32'(bus.redirect_pc), 32'h0102);
            chk("hold_flush", 32'(flush), 32'd0);
            chk("hold_ignored", 32'(outstanding), 32'd0);
        end
        accept_redirect();
        chk("hold_release", 32'(bus.redirect_v), 32'd0);

        push(1, 16'h0800, 16'h0802);
        resolve(1, 16'h0804);
        chk("tgt_mis_pc", 32'(bus.redirect_pc), 32'h0804);
        accept_redirect();

        for (int i = 0; i < 3; i++) push(i[0], 16'h1000 + 16'(i * 16), 16'h2000 + 16'(i));
        for (int i = 3; i < 9; i++) begin
            set_pred(i[0], 16'h1000 + 16'(i * 16), 16'h2000 + 16'(i));
            resolve_head_ok(); tick(); idle();
        end
        for (int i = 0; i < 3; i++) begin
            resolve_head_ok(); tick(); idle();
        end
        chk("wrap_drained", 32'(outstanding), 32'd0);
        chk("wrap_no_redirect", 32'(bus.redirect_v), 32'd0);

        resolve(0, 16'h0000);
        chk("empty_err", 32'(err), 32'd1);
        chk("empty_no_redirect", 32'(bus.redirect_v), 32'd0);
        tick();
        chk("err_sticky", 32'(err), 32'd1);

        push(0, 16'h0900, 16'h0902);
        resolve(1, 16'h0900);
        chk("pre_reset_v", 32'(bus.redirect_v), 32'd1);
        reset_i = 1; tick(); reset_i = 0;
        chk("reset_redirect_v", 32'(bus.redirect_v), 32'd0);
        chk("reset_err", 32'(err), 32'd0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);

        push(1, 16'h0a00, 16'h0a02);
        push(0, 16'h0a10, 16'h0a12);
        push(1, 16'h0a20, 16'h0a22);
        resolve(1, 16'h0a00);
        resolve(0, 16'h0000);
        resolve(1, 16'h0a20);
        push(1, 16'h0b00, 16'h0b02);
        resolve(0, 16'h0000);
        accept_redirect();
        push(0, 16'h0c00, 16'h0c02);
        resolve(1, 16'h0c00);
        accept_redirect();
`ifdef BRANCH_RESOLVE_STATS_EN
        chk("stats_resolved", 32'(resolved_cnt), 32'd5);
        chk("stats_mispredict", 32'(mispredict_cnt), 32'd2);
`endif
        tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
